// File: rtl/cnn_frame_loader_if.sv
// Byte stream channel (valid/ready with end-of-packet marker) shared by the
// pixel input and result output sides of cnn_frame_loader.
interface cnn_frame_loader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;
  logic                  ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/cnn_frame_loader.sv
// cnn_frame_loader: collects a raster-ordered pixel stream into a frame
// buffer, fires the CNN core with a one-cycle start pulse, waits (bounded)
// for its logits, and streams them back out one byte per beat.
// Optional build macro CNN_LOADER_ARGMAX_EN appends a final beat carrying
// the index of the largest (signed) logit, lowest index on ties.
module cnn_frame_loader #(
  parameter int IMG_SIZE       = 28,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_CLASSES    = 2,
  parameter int RESULT_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  cnn_frame_loader_if.slave     s_if,
  cnn_frame_loader_if.master    m_if,
  output logic [DATA_WIDTH-1:0] image_out [0:IMG_SIZE*IMG_SIZE-1],
  output logic                  start_out,
  input  logic                  core_valid,
  input  logic [DATA_WIDTH-1:0] class_in [0:NUM_CLASSES-1],
  output logic                  frame_err,
  output logic [1:0]            err_code
);

  localparam int N  = IMG_SIZE * IMG_SIZE;
  localparam int CW = $clog2(N);
  localparam int TW = $clog2(RESULT_TIMEOUT + 1);
`ifdef CNN_LOADER_ARGMAX_EN
  localparam int NB = NUM_CLASSES + 1;
`else
  localparam int NB = NUM_CLASSES;
`endif
  localparam int BW = $clog2(NB + 1);

  localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(RESULT_TIMEOUT);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

  typedef enum logic [2:0] {S_LOAD, S_DRAIN, S_FIRE, S_WAIT, S_SEND} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tmo_q, tmo_d, tmo_inc;
  logic [BW-1:0]         beat_q, beat_d, next_beat;
  logic                  ready_q, ready_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d, next_byte;
  logic                  m_last_q, m_last_d;
  logic                  frame_err_q, frame_err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  s_hs, m_hs, pix_we, capture;

  // Data storage: frame buffer and captured logits carry no reset.
  logic [DATA_WIDTH-1:0] pix_q [0:N-1];
  logic [DATA_WIDTH-1:0] res_q [0:NUM_CLASSES-1];

`ifdef CNN_LOADER_ARGMAX_EN
  logic signed [DATA_WIDTH-1:0] amax_best;
  logic [DATA_WIDTH-1:0]        amax_c, amax_q;

  // Index of the largest signed logit; strict compare keeps the lowest index on ties.
  always_comb begin
    amax_best = class_in[0];
    amax_c    = '0;
    for (int i = 1; i < NUM_CLASSES; i++) begin
      if ($signed(class_in[i]) > amax_best) begin
        amax_best = class_in[i];
        amax_c    = DATA_WIDTH'(i);
      end
    end
  end
`endif

  // Byte that the following result beat will carry.
  always_comb begin
    next_beat = beat_q + BW'(1);
    next_byte = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (next_beat == BW'(i)) next_byte = res_q[i];
    end
`ifdef CNN_LOADER_ARGMAX_EN
    if (next_beat == BW'(NUM_CLASSES)) next_byte = amax_q;
`endif
  end

  // Next-state and output decode for the load/fire/wait/send sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    beat_d      = beat_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    pix_we      = 1'b0;
    capture     = 1'b0;
    s_hs        = s_if.valid & ready_q;
    m_hs        = m_valid_q & m_if.ready;
    tmo_inc     = tmo_q + TW'(1);

    case (state_q)
      S_LOAD: begin
        if (s_hs) begin
          pix_we = 1'b1;
          if (s_if.last) begin
            cnt_d = '0;
            if (cnt_q == LAST_IDX) begin
              state_d = S_FIRE;
            end else begin
              frame_err_d = 1'b1;
              err_code_d  = 2'd1;
            end
          end else if (cnt_q == LAST_IDX) begin
            // Frame overran the buffer: discard the rest up to s_last.
            cnt_d       = '0;
            frame_err_d = 1'b1;
            err_code_d  = 2'd2;
            state_d     = S_DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (s_hs && s_if.last) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_FIRE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_valid) begin
          capture   = 1'b1;
          tmo_d     = '0;
          beat_d    = '0;
          m_valid_d = 1'b1;
          m_data_d  = class_in[0];
          m_last_d  = (NB == 1);
          state_d   = S_SEND;
        end else if (tmo_inc == TMO_LIMIT) begin
          tmo_d       = '0;
          cnt_d       = '0;
          frame_err_d = 1'b1;
          err_code_d  = 2'd3;
          state_d     = S_LOAD;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      S_SEND: begin
        if (m_hs) begin
          if (m_last_q) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            m_data_d  = '0;
            cnt_d     = '0;
            state_d   = S_LOAD;
          end else begin
            beat_d   = next_beat;
            m_data_d = next_byte;
            m_last_d = (next_beat == LAST_BEAT);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase

    // Ready is registered so it is low throughout reset and rises on the first edge after.
    ready_d = (state_d == S_LOAD) || (state_d == S_DRAIN);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      tmo_q       <= '0;
      beat_q      <= '0;
      ready_q     <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      beat_q      <= beat_d;
      ready_q     <= ready_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Pixel buffer writes and logit capture.
  always_ff @(posedge clk) begin
    if (pix_we) pix_q[cnt_q] <= s_if.data;
    if (capture) begin
      res_q <= class_in;
`ifdef CNN_LOADER_ARGMAX_EN
      amax_q <= amax_c;
`endif
    end
  end

  assign image_out  = pix_q;
  assign start_out  = (state_q == S_FIRE);
  assign s_if.ready = ready_q;
  assign m_if.valid = m_valid_q;
  assign m_if.data  = m_data_q;
  assign m_if.last  = m_last_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_cnn_frame_loader.sv
// Testbench for cnn_frame_loader: table of frame scenarios plus hand-written
// timeout, backpressure and asynchronous-reset sequences; result beats are
// checked through an expected-value queue.
module tb_cnn_frame_loader;
  localparam int N = 784;
  localparam int T = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_frame_loader_if #(.DATA_WIDTH(8)) s_if ();
  cnn_frame_loader_if #(.DATA_WIDTH(8)) m_if ();

  logic [7:0] image_out [0:N-1];
  logic       start_out;
  logic       core_valid;
  logic [7:0] class_in [0:1];
  logic       frame_err;
  logic [1:0] err_code;

  cnn_frame_loader dut (
    .clk        (clk),
    .rst        (rst),
    .s_if       (s_if),
    .m_if       (m_if),
    .image_out  (image_out),
    .start_out  (start_out),
    .core_valid (core_valid),
    .class_in   (class_in),
    .frame_err  (frame_err),
    .err_code   (err_code)
  );

  int total = 0;
  int bad   = 0;
  int starts = 0;
  int errs   = 0;
  int stalls = 0;
  logic [8:0] exp_q [$];

  typedef struct {
    int         len;
    int         last_at;
    int         off;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [1:0] exp_err;
    bit         exp_start;
  } vec_t;
  vec_t vec [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse, error and result-beat monitor, sampled on the falling edge.
  always @(negedge clk) begin : mon
    logic [8:0] e;
    if (start_out === 1'b1) starts++;
    if (frame_err === 1'b1) errs++;
    if (m_if.valid === 1'b1 && m_if.ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {23'd0, m_if.last, m_if.data}, 32'h1FF);
      end else begin
        e = exp_q.pop_front();
        chk("m_data", m_if.data, e[7:0]);
        chk("m_last", m_if.last, e[8]);
      end
    end
  end

  function automatic logic [7:0] model_argmax(input logic [7:0] a, input logic [7:0] b);
    logic signed [7:0] sa, sb;
    sa = a;
    sb = b;
    return (sb > sa) ? 8'd1 : 8'd0;
  endfunction

  task automatic push_byte(input logic [7:0] d, input logic l, output bit ok);
    int guard;
    guard = 0;
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.last  = l;
    while (s_if.ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
      stalls++;
    end
    ok = (guard < 20);
    if (!ok) chk("s_ready_timeout", 32'd0, 32'd1);
    tick();
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
  endtask

  task automatic send_frame(input int len, input int last_at, input int off);
    bit ok;
    for (int i = 0; i < len; i++) begin
      push_byte(8'(i + off), (i == last_at - 1), ok);
      if (!ok) break;
    end
  endtask

  task automatic respond(input logic [7:0] c0, input logic [7:0] c1);
    class_in[0] = c0;
    class_in[1] = c1;
    core_valid  = 1'b1;
    exp_q.push_back({1'b0, c0});
`ifdef CNN_LOADER_ARGMAX_EN
    exp_q.push_back({1'b0, c1});
    exp_q.push_back({1'b1, model_argmax(c0, c1)});
`else
    exp_q.push_back({1'b1, c1});
`endif
    tick();
    core_valid = 1'b0;
  endtask

  task automatic drain_results();
    int guard;
    guard = 0;
    m_if.ready = 1'b1;
    while ((exp_q.size() != 0 || m_if.valid === 1'b1) && guard < 50) begin
      tick();
      guard++;
    end
    chk("results_drained", guard < 50, 1);
    chk("s_ready_after_send", s_if.ready, 1);
    exp_q.delete();
  endtask

  task automatic fire_and_check(input int off);
    chk("start_out_pulse", start_out, 1);
    chk("image_0", image_out[0], 8'(off));
    chk("image_300", image_out[300], 8'(300 + off));
    chk("image_783", image_out[783], 8'(783 + off));
    tick();
    chk("start_out_single", start_out, 0);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, e0;
    vec[0] = '{784, 784, 0, 8'h05, 8'hFB, 2'd0, 1'b1};
    vec[1] = '{100, 100, 0, 8'h00, 8'h00, 2'd1, 1'b0};
    vec[2] = '{784, 784, 7, 8'h80, 8'h7F, 2'd0, 1'b1};
    vec[3] = '{790, 790, 0, 8'h00, 8'h00, 2'd2, 1'b0};
    vec[4] = '{784, 784, 3, 8'h33, 8'h33, 2'd0, 1'b1};

    rst = 1'b1;
    s_if.valid = 1'b0;
    s_if.data  = 8'h00;
    s_if.last  = 1'b0;
    m_if.ready = 1'b1;
    core_valid = 1'b0;
    class_in[0] = 8'h00;
    class_in[1] = 8'h00;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", s_if.ready, 0);
    chk("rst_start", start_out, 0);
    chk("rst_m_valid", m_if.valid, 0);
    chk("rst_m_last", m_if.last, 0);
    chk("rst_m_data", m_if.data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_code", err_code, 0);
    rst = 1'b1;
    tick();
    chk("s_ready_after_release", s_if.ready, 1);

    // Frame scenario table.
    for (int v = 0; v < 5; v++) begin
      s0 = starts;
      e0 = errs;
      stalls = 0;
      send_frame(vec[v].len, vec[v].last_at, vec[v].off);
      if (vec[v].exp_start) begin
        fire_and_check(vec[v].off);
        respond(vec[v].c0, vec[v].c1);
        drain_results();
        chk("vec_no_err", errs - e0, 0);
        chk("vec_one_start", starts - s0, 1);
      end else begin
        if (vec[v].exp_err == 2'd1) chk("short_err_now", frame_err, 1);
        tick();
        tick();
        chk("vec_err_count", errs - e0, 1);
        chk("vec_err_code", err_code, vec[v].exp_err);
        chk("vec_no_start", starts - s0, 0);
        chk("vec_no_stall", stalls, 0);
        chk("vec_ready_back", s_if.ready, 1);
      end
    end

    // Result timeout: error lands exactly T cycles after entering WAIT.
    send_frame(N, N, 1);
    chk("tmo_start", start_out, 1);
    tick();
    e0 = errs;
    repeat (T - 1) tick();
    chk("tmo_not_early", frame_err, 0);
    chk("tmo_ready_low", s_if.ready, 0);
    tick();
    chk("tmo_pulse", frame_err, 1);
    chk("tmo_code", err_code, 3);
    chk("tmo_ready_back", s_if.ready, 1);
    core_valid = 1'b1;
    tick();
    core_valid = 1'b0;
    tick();
    chk("core_valid_in_load_ignored", m_if.valid, 0);
    chk("tmo_err_count", errs - e0, 1);

    // Result backpressure with a stray core_valid during SEND.
    send_frame(N, N, 0);
    fire_and_check(0);
    m_if.ready = 1'b0;
    respond(8'h05, 8'hFB);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        class_in[0] = 8'hAA;
        class_in[1] = 8'hBB;
        core_valid  = 1'b1;
      end
      tick();
      core_valid = 1'b0;
      chk("bp_m_valid", m_if.valid, 1);
      chk("bp_m_data_hold", m_if.data, 8'h05);
      chk("bp_s_ready_low", s_if.ready, 0);
    end
    drain_results();

    // Asynchronous reset in the middle of a frame.
    send_frame(400, 0, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_s_ready", s_if.ready, 0);
    chk("mid_rst_start", start_out, 0);
    chk("mid_rst_m_valid", m_if.valid, 0);
    chk("mid_rst_frame_err", frame_err, 0);
    chk("mid_rst_err_code", err_code, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_ready_back", s_if.ready, 1);
    s0 = starts;
    send_frame(N, N, 9);
    fire_and_check(9);
    respond(8'h80, 8'h7F);
    drain_results();
    chk("post_rst_one_start", starts - s0, 1);

    // Asynchronous reset while a result is pending.
    send_frame(N, N, 2);
    fire_and_check(2);
    m_if.ready = 1'b0;
    respond(8'h11, 8'h22);
    tick();
    chk("send_m_valid", m_if.valid, 1);
    rst = 1'b0;
    #1;
    chk("send_rst_m_valid", m_if.valid, 0);
    chk("send_rst_m_data", m_if.data, 0);
    chk("send_rst_m_last", m_if.last, 0);
    chk("send_rst_s_ready", s_if.ready, 0);
    exp_q.delete();
    tick();
    rst = 1'b1;
    m_if.ready = 1'b1;
    tick();
    chk("send_rst_ready_back", s_if.ready, 1);
    chk("send_rst_no_valid", m_if.valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
